// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: PC width default, PC field extraction,
// and direction-counter reset/allocate constants.
package bp_pkg;

  localparam int PC_W_DEF = 32;

  // Table index: word-aligned PC bits just above the byte offset.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Tag: every PC bit above the index field.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

  // Weakly-taken value given to a freshly allocated entry.
  function automatic int ctr_wt(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  // Weakly-not-taken value loaded at reset (0 for a single-bit counter).
  function automatic int ctr_wnt(input int ctr_w);
    return ctr_wt(ctr_w) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down next-state logic for one direction counter.
module bp_sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_inc,
  output logic [CTR_W-1:0] o_ctr
);

  // Step toward the outcome, holding at all-ones or zero.
  always_comb begin
    o_ctr = i_ctr;
    if (i_inc) begin
      if (i_ctr != '1) o_ctr = i_ctr + 1'b1;
    end else if (i_ctr != '0) begin
      o_ctr = i_ctr - 1'b1;
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Multi-port branch target buffer with saturating-counter direction
// prediction. ISSUE combinational lookups, ISSUE resolved updates per cycle.
module bpred_btb
  import bp_pkg::*;
#(
  parameter int ISSUE   = 2,
  parameter int ENTRIES = 16,
  parameter int PC_W    = PC_W_DEF,
  parameter int CTR_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ISSUE*PC_W-1:0] lookup_pc,
  output logic [ISSUE-1:0]      pred_taken,
  output logic [ISSUE*PC_W-1:0] pred_target,
  input  logic [ISSUE-1:0]      upd_valid,
  input  logic [ISSUE*PC_W-1:0] upd_pc,
  input  logic [ISSUE-1:0]      upd_taken,
  input  logic [ISSUE*PC_W-1:0] upd_target,
  input  logic                  invalidate
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] WT  = CTR_W'(ctr_wt(CTR_W));
  localparam logic [CTR_W-1:0] WNT = CTR_W'(ctr_wnt(CTR_W));

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [PC_W-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0] r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx  [ISSUE];
  logic [TAG_W-1:0] w_lk_tag  [ISSUE];
  logic [IDX_W-1:0] w_upd_idx [ISSUE];
  logic [TAG_W-1:0] w_upd_tag [ISSUE];
  logic [CTR_W-1:0] w_ctr_nxt [ISSUE];
  logic [ISSUE-1:0] w_upd_hit;
  logic [ISSUE-1:0] w_upd_act;

  for (genvar g = 0; g < ISSUE; g++) begin : g_slot
    assign w_lk_idx[g]  = IDX_W'(pc_index(64'(lookup_pc[g*PC_W +: PC_W]), IDX_W));
    assign w_lk_tag[g]  = TAG_W'(pc_tag(64'(lookup_pc[g*PC_W +: PC_W]), IDX_W));
    assign w_upd_idx[g] = IDX_W'(pc_index(64'(upd_pc[g*PC_W +: PC_W]), IDX_W));
    assign w_upd_tag[g] = TAG_W'(pc_tag(64'(upd_pc[g*PC_W +: PC_W]), IDX_W));
    assign w_upd_hit[g] = r_valid[w_upd_idx[g]] && (r_tag[w_upd_idx[g]] == w_upd_tag[g]);

    bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .i_ctr (r_ctr[w_upd_idx[g]]),
      .i_inc (upd_taken[g]),
      .o_ctr (w_ctr_nxt[g])
    );
  end

  // Lookup reads pre-update state; a miss returns not-taken, target 0.
  always_comb begin
    pred_taken  = '0;
    pred_target = '0;
    for (int i = 0; i < ISSUE; i++) begin
      if (r_valid[w_lk_idx[i]] && (r_tag[w_lk_idx[i]] == w_lk_tag[i])) begin
        pred_taken[i]              = r_ctr[w_lk_idx[i]][CTR_W-1];
        pred_target[i*PC_W +: PC_W] = r_target[w_lk_idx[i]];
      end
    end
  end

  // An update slot is dropped when any younger valid slot targets its index,
  // so the youngest slot owns that entry outright this cycle.
  always_comb begin
    w_upd_act = upd_valid;
    for (int i = 0; i < ISSUE; i++) begin
      for (int j = i + 1; j < ISSUE; j++) begin
        if (upd_valid[j] && (w_upd_idx[j] == w_upd_idx[i])) w_upd_act[i] = 1'b0;
      end
    end
  end

  // Table state: reset > invalidate > per-slot updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < ENTRIES; e++) begin
        r_valid[e]  <= 1'b0;
        r_tag[e]    <= '0;
        r_target[e] <= '0;
        r_ctr[e]    <= WNT;
      end
    end else if (invalidate) begin
      for (int e = 0; e < ENTRIES; e++) r_valid[e] <= 1'b0;
    end else begin
      for (int i = 0; i < ISSUE; i++) begin
        if (w_upd_act[i]) begin
          if (w_upd_hit[i]) begin
            r_ctr[w_upd_idx[i]] <= w_ctr_nxt[i];
            if (upd_taken[i]) r_target[w_upd_idx[i]] <= upd_target[i*PC_W +: PC_W];
          end else if (upd_taken[i]) begin
            r_valid[w_upd_idx[i]]  <= 1'b1;
            r_tag[w_upd_idx[i]]    <= w_upd_tag[i];
            r_target[w_upd_idx[i]] <= upd_target[i*PC_W +: PC_W];
            r_ctr[w_upd_idx[i]]    <= WT;
          end
        end
      end
    end
  end

endmodule
